// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, reset vector, NOP word
// and a saturating increment used by the optional FETCH_PERF_COUNT_EN counters.
package instruction_fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_HOLD     = 2'd2,
        ST_REDIRECT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_pc_next_select.sv
// Combinational next-PC selection: redirect priority JR > branch > jump, word-aligns the
// chosen target and flags a misaligned one; otherwise the sequential PC+4.
module pc_next_select
    import instruction_fetch_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic        misaligned
);

    logic [31:0] target;

    always_comb begin
        target   = '0;
        redirect = jr | branch_taken | jump;
        if (jr) begin
            target = jr_target;
        end else if (branch_taken) begin
            target = branch_target;
        end else if (jump) begin
            target = jump_target;
        end
        misaligned = redirect && (target[1:0] != 2'b00);
        next_pc    = redirect ? {target[31:2], 2'b00} : pc + PC_STEP;
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage with PC register, IF/ID pipeline register and fetch FSM.
// Optional macro FETCH_PERF_COUNT_EN adds saturating fetch/stall/flush counters.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Jump,
    input  logic [31:0] Jump_Target,
    input  logic        JR,
    input  logic [31:0] JR_Target,
    output logic [31:0] Imem_Addr,
    input  logic [31:0] Imem_Data,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC_Plus4,
    output logic        IF_ID_Valid,
    output logic [5:0]  Opcode,
    output logic [5:0]  Function,
    output logic [1:0]  Fetch_State,
`ifdef FETCH_PERF_COUNT_EN
    output logic [31:0] Fetch_Count,
    output logic [31:0] Stall_Count,
    output logic [31:0] Flush_Count,
`endif
    output logic        Addr_Fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic         fault_q, fault_d;

    logic [31:0]  sel_next_pc;
    logic         sel_redirect;
    logic         sel_misaligned;
    logic         act_advance, act_stall, act_redirect;

    pc_next_select u_pc_next_select (
        .pc            (pc_q),
        .branch_taken  (Branch_Taken),
        .branch_target (Branch_Target),
        .jump          (Jump),
        .jump_target   (Jump_Target),
        .jr            (JR),
        .jr_target     (JR_Target),
        .next_pc       (sel_next_pc),
        .redirect      (sel_redirect),
        .misaligned    (sel_misaligned)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            default: begin
                if (sel_redirect) begin
                    state_d = ST_REDIRECT;
                end else if (Stall) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // BOOT suppresses every action, so requests made then are simply dropped.
    always_comb begin
        act_redirect = (state_q != ST_BOOT) && sel_redirect;
        act_stall    = (state_q != ST_BOOT) && !sel_redirect && Stall;
        act_advance  = (state_q != ST_BOOT) && !sel_redirect && !Stall;
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        if (act_redirect) begin
            pc_d    = sel_next_pc;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            fault_d = fault_q | sel_misaligned;
        end else if (act_advance) begin
            pc_d    = sel_next_pc;
            instr_d = Imem_Data;
            pc4_d   = sel_next_pc;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pc_q    <= PC_RESET_VEC;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign Imem_Addr         = pc_q;
    assign IF_ID_Instruction = instr_q;
    assign IF_ID_PC_Plus4    = pc4_q;
    assign IF_ID_Valid       = valid_q;
    assign Opcode            = instr_q[31:26];
    assign Function          = instr_q[5:0];
    assign Fetch_State       = state_q;
    assign Addr_Fault        = fault_q;

`ifdef FETCH_PERF_COUNT_EN
    // Index 0 = advance, 1 = stall, 2 = redirect.
    logic [2:0]        cnt_inc;
    logic [2:0][31:0]  cnt_all;

    assign cnt_inc = {act_redirect, act_stall, act_advance};

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [31:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_inc[gi] ? sat_inc(cnt_q) : cnt_q;
        end

        always_ff @(posedge Clk) begin
            if (!Reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_all[gi] = cnt_q;
    end

    assign Fetch_Count = cnt_all[0];
    assign Stall_Count = cnt_all[1];
    assign Flush_Count = cnt_all[2];
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed vector table, a hand-written
// stall sequence and randomized traffic against a rule-level reference model.
module tb_instruction_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Stall;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Jump;
    logic [31:0] Jump_Target;
    logic        JR;
    logic [31:0] JR_Target;
    logic [31:0] Imem_Addr;
    logic [31:0] Imem_Data;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PC_Plus4;
    logic        IF_ID_Valid;
    logic [5:0]  Opcode;
    logic [5:0]  Function;
    logic [1:0]  Fetch_State;
    logic        Addr_Fault;
`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] Fetch_Count, Stall_Count, Flush_Count;
`endif

    always #5 Clk = ~Clk;

    instruction_fetch_stage dut (
        .Clk               (Clk),
        .Reset_n           (Reset_n),
        .Stall             (Stall),
        .Branch_Taken      (Branch_Taken),
        .Branch_Target     (Branch_Target),
        .Jump              (Jump),
        .Jump_Target       (Jump_Target),
        .JR                (JR),
        .JR_Target         (JR_Target),
        .Imem_Addr         (Imem_Addr),
        .Imem_Data         (Imem_Data),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PC_Plus4    (IF_ID_PC_Plus4),
        .IF_ID_Valid       (IF_ID_Valid),
        .Opcode            (Opcode),
        .Function          (Function),
        .Fetch_State       (Fetch_State),
`ifdef FETCH_PERF_COUNT_EN
        .Fetch_Count       (Fetch_Count),
        .Stall_Count       (Stall_Count),
        .Flush_Count       (Flush_Count),
`endif
        .Addr_Fault        (Addr_Fault)
    );

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, a[15:0] ^ 16'h0021};
    endfunction

    assign Imem_Data = imem_fn(Imem_Addr);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state updated by the fetch rules.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_fault;
    int          m_state;   // 0 BOOT, 1 RUN, 2 HOLD, 3 REDIRECT
    logic [31:0] m_fetch, m_stall, m_flush;

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_step();
        logic [31:0] tgt;
        if (!Reset_n) begin
            m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fault = 0; m_state = 0;
            m_fetch = 0; m_stall = 0; m_flush = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (JR || Branch_Taken || Jump) begin
            tgt = JR ? JR_Target : (Branch_Taken ? Branch_Target : Jump_Target);
            if (tgt % 4 != 0) m_fault = 1;
            m_pc    = tgt - (tgt % 4);
            m_instr = 0;
            m_valid = 0;
            m_state = 3;
            m_flush = sat1(m_flush);
        end else if (Stall) begin
            m_state = 2;
            m_stall = sat1(m_stall);
        end else begin
            m_instr = imem_fn(m_pc);
            m_pc    = m_pc + 4;
            m_pc4   = m_pc;
            m_valid = 1;
            m_state = 1;
            m_fetch = sat1(m_fetch);
        end
    endtask

    task automatic compare_model();
        check("imem_addr", Imem_Addr, m_pc);
        check("instr", IF_ID_Instruction, m_instr);
        check("pc_plus4", IF_ID_PC_Plus4, m_pc4);
        check("valid", {31'b0, IF_ID_Valid}, {31'b0, m_valid});
        check("opcode", {26'b0, Opcode}, {26'b0, m_instr[31:26]});
        check("function", {26'b0, Function}, {26'b0, m_instr[5:0]});
        check("state", {30'b0, Fetch_State}, m_state);
        check("addr_fault", {31'b0, Addr_Fault}, {31'b0, m_fault});
`ifdef FETCH_PERF_COUNT_EN
        check("fetch_count", Fetch_Count, m_fetch);
        check("stall_count", Stall_Count, m_stall);
        check("flush_count", Flush_Count, m_flush);
`endif
    endtask

    // One clock: model consumes the same inputs the DUT sees at this edge.
    task automatic cycle();
        model_step();
        @(posedge Clk);
        #1;
        compare_model();
    endtask

    task automatic drive(input bit rst_n, input bit st, input bit br, input logic [31:0] br_t,
                         input bit j, input logic [31:0] j_t, input bit jr, input logic [31:0] jr_t);
        Reset_n = rst_n; Stall = st;
        Branch_Taken = br; Branch_Target = br_t;
        Jump = j; Jump_Target = j_t;
        JR = jr; JR_Target = jr_t;
    endtask

    typedef struct {
        bit          rst_n;
        bit          stall;
        bit          br;
        logic [31:0] br_t;
        bit          j;
        logic [31:0] j_t;
        bit          jr;
        logic [31:0] jr_t;
        logic [31:0] e_pc;
        bit          e_valid;
        logic [1:0]  e_state;
        bit          e_fault;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [31:0] held_instr, held_pc4;
        logic [31:0] r_t;

        //          rst st br br_t          j  j_t           jr jr_t          e_pc          v  st fault
        tbl[0]  = '{0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0};
        tbl[1]  = '{1, 0, 1, 32'h40,        0, 32'h0,        0, 32'h0,        32'h0,        0, 1, 0};
        tbl[2]  = '{1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h4,        1, 1, 0};
        tbl[3]  = '{1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h8,        1, 1, 0};
        tbl[4]  = '{1, 1, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h8,        1, 2, 0};
        tbl[5]  = '{1, 1, 1, 32'h40,        0, 32'h0,        0, 32'h0,        32'h40,       0, 3, 0};
        tbl[6]  = '{1, 0, 1, 32'h300,       1, 32'h200,      1, 32'h100,      32'h100,      0, 3, 0};
        tbl[7]  = '{1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h104,      1, 1, 0};
        tbl[8]  = '{1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h102,      32'h100,      0, 3, 1};
        tbl[9]  = '{1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h104,      1, 1, 1};
        tbl[10] = '{1, 0, 1, 32'h301,       1, 32'h200,      0, 32'h0,        32'h300,      0, 3, 1};
        tbl[11] = '{1, 0, 0, 32'h0,         1, 32'hFFFFFFFC, 0, 32'h0,        32'hFFFFFFFC, 0, 3, 1};
        tbl[12] = '{1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        1, 1, 1};
        tbl[13] = '{0, 1, 0, 32'h0,         0, 32'h0,        1, 32'h80,       32'h0,        0, 0, 0};
        tbl[14] = '{1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        0, 1, 0};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rst_n, tbl[i].stall, tbl[i].br, tbl[i].br_t,
                  tbl[i].j, tbl[i].j_t, tbl[i].jr, tbl[i].jr_t);
            cycle();
            $display("vec %0d: pc=0x%08h valid=%0b state=%0d fault=%0b",
                     i, Imem_Addr, IF_ID_Valid, Fetch_State, Addr_Fault);
            check("tbl_pc", Imem_Addr, tbl[i].e_pc);
            check("tbl_valid", {31'b0, IF_ID_Valid}, {31'b0, tbl[i].e_valid});
            check("tbl_state", {30'b0, Fetch_State}, {30'b0, tbl[i].e_state});
            check("tbl_fault", {31'b0, Addr_Fault}, {31'b0, tbl[i].e_fault});
            if (i == 2) check("first_instr", IF_ID_Instruction, imem_fn(32'h0));
            if (i == 5) check("redirect_opcode", {26'b0, Opcode}, 32'h0);
            if (i == 12) check("wrap_pc_plus4", IF_ID_PC_Plus4, 32'h0);
        end

        // Advance to PC=0x10, then hold three stall cycles.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        check("stall_start_pc", Imem_Addr, 32'h10);
        held_instr = IF_ID_Instruction;
        held_pc4   = IF_ID_PC_Plus4;
        check("stall_start_instr", held_instr, imem_fn(32'hC));
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            $display("stall %0d: pc=0x%08h state=%0d", i, Imem_Addr, Fetch_State);
            check("stall_pc", Imem_Addr, 32'h10);
            check("stall_instr", IF_ID_Instruction, held_instr);
            check("stall_pc4", IF_ID_PC_Plus4, held_pc4);
            check("stall_state", {30'b0, Fetch_State}, 32'd2);
        end
        Stall = 0;
        cycle();
        check("resume_pc", Imem_Addr, 32'h14);
        check("resume_instr", IF_ID_Instruction, imem_fn(32'h10));

        // Reset asserted in the middle of a redirect.
        drive(1, 0, 0, 0, 0, 0, 1, 32'h203);
        cycle();
        drive(0, 1, 1, 32'h44, 0, 0, 1, 32'h207);
        cycle();
        check("rst_redirect_pc", Imem_Addr, 32'h0);
        check("rst_redirect_state", {30'b0, Fetch_State}, 32'd0);
        check("rst_redirect_fault", {31'b0, Addr_Fault}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            Reset_n      = ($urandom_range(0, 39) != 0);
            Stall        = ($urandom_range(0, 3) == 0);
            Branch_Taken = ($urandom_range(0, 7) == 0);
            Jump         = ($urandom_range(0, 9) == 0);
            JR           = ($urandom_range(0, 11) == 0);
            for (int k = 0; k < 3; k++) begin
                r_t = $urandom;
                if ($urandom_range(0, 7) != 0) r_t[1:0] = 2'b00;
                if ($urandom_range(0, 19) == 0) r_t = 32'hFFFFFFF8;
                if (k == 0) Branch_Target = r_t;
                else if (k == 1) Jump_Target = r_t;
                else JR_Target = r_t;
            end
            cycle();
            $display("rand %0d: rst_n=%0b st=%0b br=%0b j=%0b jr=%0b pc=0x%08h state=%0d",
                     n, Reset_n, Stall, Branch_Taken, Jump, JR, Imem_Addr, Fetch_State);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Clk  input  1  single clock; all state updates on its rising edge.
REQ-002 Reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-003 Stall  input  1  load-use hold request from hazard logic.
REQ-004 Branch_Taken  input  1  BEQ resolved taken.
REQ-005 Branch_Target  input  32  BEQ target address.
REQ-006 Jump  input  1  JAL redirect request.
REQ-007 Jump_Target  input  32  JAL target address.
REQ-008 JR  input  1  jump-register redirect request.
REQ-009 JR_Target  input  32  register-sourced target address.
REQ-010 Imem_Addr  output  32  current PC, driven to instruction memory.
REQ-011 Imem_Data  input  32  instruction word at Imem_Addr, valid in the same cycle.
REQ-012 IF_ID_Instruction  output  32  registered instruction.
REQ-013 IF_ID_PC_Plus4  output  32  registered PC+4 of that instruction.
REQ-014 IF_ID_Valid  output  1  1 = IF/ID holds a real instruction.
REQ-015 Opcode  output  6  IF_ID_Instruction[31:26], feeds the control unit Instruction input.
REQ-016 Function  output  6  IF_ID_Instruction[5:0], feeds the control unit Function input.
REQ-017 Fetch_State  output  2  FSM state encoding: BOOT=0, RUN=1, HOLD=2, REDIRECT=3.
REQ-018 Addr_Fault  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Function
REQ-019 Each cycle SHALL have exactly one action, chosen by priority: redirect > stall > advance.
REQ-020 Redirect priority among simultaneous requests SHALL be JR > Branch_Taken > Jump.
REQ-021 Advance: PC <= PC+4 (mod 2^32); IF_ID_Instruction <= Imem_Data; IF_ID_PC_Plus4 <= PC+4; IF_ID_Valid <= 1.
REQ-022 Stall without redirect: PC, IF_ID_Instruction, IF_ID_PC_Plus4 and IF_ID_Valid SHALL hold.
REQ-023 Redirect, stall ignored: PC <= {target[31:2],2'b00}; IF_ID_Instruction <= 0 (NOP); IF_ID_Valid <= 0; IF_ID_PC_Plus4 holds.
REQ-024 Addr_Fault SHALL set when the selected target has [1:0] != 0, and SHALL clear only on reset.
REQ-025 PC 0xFFFF_FFFC advancing SHALL wrap to 0x0000_0000 with no flag.
REQ-026 FSM: BOOT -> RUN after one cycle, ignoring all requests.
REQ-027 FSM: RUN/HOLD/REDIRECT -> REDIRECT on redirect, else HOLD on Stall, else RUN.
REQ-028 In BOOT: PC holds; IF/ID stays NOP/invalid; the first instruction is captured in the following cycle.
REQ-029 Imem_Addr SHALL equal PC combinationally; Opcode and Function SHALL be combinational slices of IF_ID_Instruction.
REQ-030 Latency: Imem_Addr to IF_ID_Instruction is 1 cycle when neither redirect nor stall occurs.

Reset
REQ-031 On a cycle with Reset_n=0: PC=0x0000_0000, IF_ID_Instruction=0, IF_ID_PC_Plus4=0, IF_ID_Valid=0, Addr_Fault=0, state=BOOT, counters=0.
REQ-032 Reset SHALL take precedence over redirect and stall in the same cycle, including mid-stall and mid-redirect.

Configuration
REQ-033 Macro FETCH_PERF_COUNT_EN: when defined, adds outputs Fetch_Count, Stall_Count and Flush_Count (32 bits each).
REQ-034 With FETCH_PERF_COUNT_EN, the counters SHALL count advance, stall and redirect cycles respectively, saturate at 0xFFFF_FFFF, and exclude BOOT.
REQ-035 Without FETCH_PERF_COUNT_EN, the ports and counter logic SHALL be absent; all other behaviour is identical.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, the PC reset vector (0x0000_0000) and the NOP encoding (0x0000_0000).
REQ-037 Sub-module pc_next_select SHALL be combinational: it applies redirect priority, target alignment and fault detection, and returns the next PC and redirect flag.

Verification
REQ-038 Reset released, Imem returns addr-indexed words -> BOOT 1 cycle; Imem_Addr then 0,4,8; IF_ID_Instruction = word@0 with Valid=1 two cycles after release.
REQ-039 Stall held 3 cycles at PC=0x10 -> PC stays 0x10 and IF/ID unchanged for 3 cycles; state HOLD; advance resumes the next cycle.
REQ-040 Branch_Taken=1, Branch_Target=0x40, Stall=1 together -> next PC 0x40, IF_ID_Valid=0, Opcode=0, state REDIRECT.
REQ-041 JR=1 (0x100), Jump=1 (0x200) and Branch_Taken=1 (0x300) together -> PC 0x100; JR_Target=0x102 -> PC 0x100 and Addr_Fault=1 until reset.
REQ-042 PC=0xFFFF_FFFC, advance -> PC 0x0000_0000 and IF_ID_PC_Plus4=0x0000_0000.
REQ-043 Reset_n=0 during a redirect cycle -> PC=0, state BOOT, Addr_Fault=0; with FETCH_PERF_COUNT_EN, all counters = 0.
